instr_sequencer: RTL and testbench

//  Front-end stage that feeds the IO/Control/Reg/ALU datapath. Operators enter
//  16-bit instructions as four 4-bit nibbles from sw[3:0] into a small program

---
 rtl/seq_defs.sv | 28 ++
 rtl/prog_buffer.sv | 23 ++
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_defs.sv
// Shared definitions for the instruction sequencer front end.
// Sizes, FSM state encoding and instruction field positions.
package seq_defs;

  localparam int DEPTH      = 8;
  localparam int AW         = 3;
  localparam int PHASE_GAP  = 4;
  localparam int PW         = $clog2(PHASE_GAP);
  localparam int NIBBLES    = 4;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OVF   = 3'd3,
    S_STORE = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

  function automatic logic [3:0] opcode_of(
    input logic [15:0] word
  );
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program word store: synchronous write, asynchronous read.
// Contents are not reset; only words below count are ever read.
module prog_buffer
  import seq_defs::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // write one word per enabled cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Nibble entry, program replay and phase-strobe generation.
// Strobes are registered and issued on the first cycle of each phase.
module instr_sequencer
  import seq_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    sw,
  input  logic          load_pulse,
  input  logic          go_pulse,
  input  logic          clr_pulse,
  input  logic          run_all,
  output logic [15:0]   instruction,
  output logic          Execute_St,
  output logic          Overflow_St,
  output logic          Reg_Store,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic [1:0]    nib_idx,
  output logic          busy,
  output logic          full
);

  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_GAP - 1);
  localparam logic [1:0]    NIB_LAST = 2'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] pc_d;
  logic [AW:0]   pc_next;
  logic          phase_done;
  logic          fetch;
  logic          exe_d, ovf_d, sto_d;
  logic [11:0]   shreg;
  logic          load_ok;
  logic          word_done;
  logic          we;
  logic [15:0]   wdata;
  logic [15:0]   rdata;

  assign busy       = (state_q != S_IDLE);
  assign full       = (count == (AW+1)'(DEPTH));
  assign phase_done = (phase_q == PH_LAST);
  assign pc_next    = {1'b0, pc} + (AW+1)'(1);

  assign load_ok   = (state_q == S_IDLE) && load_pulse
                  && !go_pulse && !clr_pulse && !full;
  assign word_done = (nib_idx == NIB_LAST);
  assign we        = load_ok && word_done;
  assign wdata     = {shreg, sw};

  prog_buffer u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (count[AW-1:0]),
    .wdata (wdata),
    .raddr (pc_d),
    .rdata (rdata)
  );

  // next state, phase timing, pc advance and strobe requests
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pc_d    = pc;
    fetch   = 1'b0;
    exe_d   = 1'b0;
    ovf_d   = 1'b0;
    sto_d   = 1'b0;
    if (clr_pulse) begin
      state_d = S_IDLE;
      phase_d = '0;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go_pulse && count != '0) begin
            state_d = S_FETCH;
            phase_d = '0;
            fetch   = 1'b1;
          end
        end
        S_FETCH: begin
          if (phase_done) begin
            state_d = S_EXEC;
            phase_d = '0;
            exe_d   = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_EXEC: begin
          if (phase_done) begin
            state_d = S_OVF;
            phase_d = '0;
            ovf_d   = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_OVF: begin
          if (phase_done) begin
            state_d = S_STORE;
            phase_d = '0;
            sto_d   = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_STORE: begin
          if (phase_done) begin
            state_d = S_NEXT;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (pc_next == count) begin
            pc_d    = '0;
            state_d = S_IDLE;
          end else if (run_all) begin
            pc_d    = pc_next[AW-1:0];
            state_d = S_FETCH;
            phase_d = '0;
            fetch   = 1'b1;
          end else begin
            pc_d    = pc_next[AW-1:0];
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  // FSM state, pc, fetched word and phase strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      pc          <= '0;
      instruction <= '0;
      Execute_St  <= 1'b0;
      Overflow_St <= 1'b0;
      Reg_Store   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pc          <= pc_d;
      Execute_St  <= exe_d;
      Overflow_St <= ovf_d;
      Reg_Store   <= sto_d;
      if (fetch) instruction <= rdata;
    end
  end

  // nibble shift register, nibble index and word count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      nib_idx <= '0;
      count   <= '0;
    end else if (clr_pulse) begin
      shreg   <= '0;
      nib_idx <= '0;
      count   <= '0;
    end else if (load_ok) begin
      shreg   <= {shreg[7:0], sw};
      nib_idx <= nib_idx + 2'd1;
      if (word_done) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Schedule model plus directed literal checks.
module tb_instr_sequencer;

  localparam int GAP = 4;
  localparam int NW  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw = '0;
  logic        load_pulse = 1'b0;
  logic        go_pulse = 1'b0;
  logic        clr_pulse = 1'b0;
  logic        run_all = 1'b0;
  logic [15:0] instruction;
  logic        Execute_St, Overflow_St, Reg_Store;
  logic [2:0]  pc;
  logic [3:0]  count;
  logic [1:0]  nib_idx;
  logic        busy, full;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .load_pulse  (load_pulse),
    .go_pulse    (go_pulse),
    .clr_pulse   (clr_pulse),
    .run_all     (run_all),
    .instruction (instruction),
    .Execute_St  (Execute_St),
    .Overflow_St (Overflow_St),
    .Reg_Store   (Reg_Store),
    .pc          (pc),
    .count       (count),
    .nib_idx     (nib_idx),
    .busy        (busy),
    .full        (full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word occupies 4*GAP+1 edges from the edge that fetches it;
  // strobes fall GAP, 2*GAP and 3*GAP edges after that fetch edge.
  logic [15:0] m_mem [NW];
  logic [15:0] m_instr = '0;
  logic [11:0] m_shreg = '0;
  logic [15:0] m_word;
  int m_count = 0, m_pc = 0, m_nib = 0;
  int m_start = 0, cyc = 0, m_off = 0;
  bit m_run = 0, m_e = 0, m_o = 0, m_r = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_instr = '0; m_shreg = '0; m_count = 0; m_pc = 0; m_nib = 0;
      m_run = 0; m_e = 0; m_o = 0; m_r = 0; cyc = 0;
    end else begin
      m_e = 0; m_o = 0; m_r = 0;
      if (clr_pulse) begin
        m_count = 0; m_pc = 0; m_nib = 0; m_shreg = '0; m_run = 0;
      end else if (m_run) begin
        m_off = cyc - m_start;
        if (m_off == GAP)     m_e = 1;
        if (m_off == 2 * GAP) m_o = 1;
        if (m_off == 3 * GAP) m_r = 1;
        if (m_off == 4 * GAP + 1) begin
          if (m_pc + 1 == m_count) begin
            m_pc = 0; m_run = 0;
          end else begin
            m_pc = m_pc + 1;
            if (run_all) begin
              m_start = cyc; m_instr = m_mem[m_pc];
            end else m_run = 0;
          end
        end
      end else if (go_pulse) begin
        if (m_count > 0) begin
          m_run = 1; m_start = cyc; m_instr = m_mem[m_pc];
        end
      end else if (load_pulse && m_count < NW) begin
        m_word  = {m_shreg, sw};
        m_shreg = m_word[11:0];
        m_nib++;
        if (m_nib == 4) begin
          m_mem[m_count] = m_word; m_count++; m_nib = 0;
        end
      end
      cyc++;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      cmp("instruction", instruction, m_instr);
      cmp("Execute_St", Execute_St, m_e);
      cmp("Overflow_St", Overflow_St, m_o);
      cmp("Reg_Store", Reg_Store, m_r);
      cmp("pc", pc, m_pc);
      cmp("count", count, m_count);
      cmp("nib_idx", nib_idx, m_nib);
      cmp("busy", busy, m_run);
      cmp("full", full, m_count == NW);
    end
  end

  task automatic load_nib(input logic [3:0] v);
    sw = v; load_pulse = 1'b1;
    @(negedge clk);
    load_pulse = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) load_nib(w[i*4 +: 4]);
  endtask

  task automatic pulse_go();
    go_pulse = 1'b1;
    @(negedge clk);
    go_pulse = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_pulse = 1'b1;
    @(negedge clk);
    clr_pulse = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk); k++;
    end
    cmp("idle_timeout", busy, 0);
  endtask

  int e_at, o_at, r_at, n_strb;
  logic [15:0] w_first, w_second;

  initial begin
    // reset with stimulus toggling
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    for (int i = 0; i < 4; i++) begin
      sw = 4'(i + 3); load_pulse = i[0]; go_pulse = ~i[0];
      @(negedge clk);
    end
    load_pulse = 0; go_pulse = 0;
    cmp("rst_busy", busy, 0);
    cmp("rst_count", count, 0);
    cmp("rst_instr", instruction, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rel_nib", nib_idx, 0);

    // entry of two words
    load_word(16'h1234);
    load_word(16'h5678);
    cmp("entry_count", count, 2);
    cmp("entry_nib", nib_idx, 0);

    // run whole buffer, measure strobe offsets from the go cycle
    run_all = 1'b1;
    e_at = -1; o_at = -1; r_at = -1;
    w_first = '0; w_second = '0;
    go_pulse = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      go_pulse = 1'b0;
      if (i == 1)  w_first = instruction;
      if (i == 18) w_second = instruction;
      if (Execute_St  && e_at < 0) e_at = i;
      if (Overflow_St && o_at < 0) o_at = i;
      if (Reg_Store   && r_at < 0) r_at = i;
    end
    cmp("run_w0", w_first, 16'h1234);
    cmp("run_e_lat", e_at, 5);
    cmp("run_o_lat", o_at, 9);
    cmp("run_r_lat", r_at, 13);
    cmp("run_w1", w_second, 16'h5678);
    wait_idle();
    cmp("run_pc", pc, 0);

    // single step
    run_all = 1'b0;
    pulse_go();
    wait_idle();
    cmp("step1_pc", pc, 1);
    cmp("step1_w", instruction, 16'h1234);
    pulse_go();
    wait_idle();
    cmp("step2_pc", pc, 0);
    cmp("step2_w", instruction, 16'h5678);

    // load while busy is ignored
    pulse_go();
    repeat (3) @(negedge clk);
    load_nib(4'h9);
    wait_idle();
    cmp("busy_nib", nib_idx, 0);
    cmp("busy_count", count, 2);
    pulse_go();
    wait_idle();
    cmp("busy_mem1", instruction, 16'h5678);

    // clear, then go on empty buffer
    pulse_clr();
    cmp("clr_count", count, 0);
    pulse_go();
    cmp("empty_go", busy, 0);

    // fill all words, one extra load
    for (int i = 0; i < NW; i++) load_word(16'(16'hA000 + i * 16'h0111));
    cmp("fill_full", full, 1);
    cmp("fill_count", count, 8);
    load_nib(4'hF);
    cmp("over_count", count, 8);
    cmp("over_nib", nib_idx, 0);

    // abort by clear during EXEC
    pulse_clr();
    load_word(16'hBEEF);
    load_word(16'hC0DE);
    run_all = 1'b1;
    pulse_go();
    for (int k = 0; k < 20 && !Execute_St; k++) @(negedge clk);
    cmp("ab_e_seen", Execute_St, 1);
    pulse_clr();
    n_strb = 0;
    for (int k = 0; k < 30; k++) begin
      if (Execute_St | Overflow_St | Reg_Store) n_strb++;
      @(negedge clk);
    end
    cmp("ab_strobes", n_strb, 0);
    cmp("ab_count", count, 0);
    cmp("ab_busy", busy, 0);

    // abort by reset during OVF
    load_word(16'h1111);
    load_word(16'h2222);
    pulse_go();
    for (int k = 0; k < 20 && !Overflow_St; k++) @(negedge clk);
    cmp("rs_o_seen", Overflow_St, 1);
    rst = 1'b0;
    n_strb = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (Execute_St | Overflow_St | Reg_Store) n_strb++;
    end
    rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (Execute_St | Overflow_St | Reg_Store) n_strb++;
    end
    cmp("rs_strobes", n_strb, 0);
    cmp("rs_count", count, 0);
    cmp("rs_busy", busy, 0);

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
